// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding and width helpers for the PLL reset sequencer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT,
    BYPASS
  } state_t;

  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Never narrower than 2 bits so small retry limits keep a usable status field.
  function automatic int retry_width(input int max_retries);
    int w;
    w = $clog2(max_retries + 1);
    return (w < 2) ? 2 : w;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - PLL control, lock input and status bundle of the sequencer
interface pll_reset_sequencer_if #(
  parameter int RC_W  = 2,
  parameter int CNT_W = 8
);
  logic             restart;
  logic             pll_lock;
  logic             pll_resetb;
  logic             pll_bypass;
  logic             sys_rst;
  logic             ready;
  logic             fault;
  logic [RC_W-1:0]  retry_count;
  logic [CNT_W-1:0] lock_loss_count;

  modport master (
    input  restart, pll_lock,
    output pll_resetb, pll_bypass, sys_rst, ready, fault, retry_count, lock_loss_count
  );

  modport slave (
    output restart, pll_lock,
    input  pll_resetb, pll_bypass, sys_rst, ready, fault, retry_count, lock_loss_count
  );
endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// rtl/pll_reset_sequencer_sync_2ff.sv - 1-bit two-flop synchroniser, async active-high reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL bring-up/lock supervisor and system reset source; optional PLL_BYPASS_FALLBACK_EN
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);
  localparam int TW   = timer_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int RC_W = retry_width(MAX_RETRIES);

`ifdef PLL_BYPASS_FALLBACK_EN
  localparam state_t EXHAUSTED = BYPASS;
`else
  localparam state_t EXHAUSTED = FAULT;
`endif

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [RC_W-1:0]  retry_q, retry_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             resetb_q, resetb_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             bypass_d;
  logic             retry_path;
  logic             lock_s;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pll_lock),
    .q   (lock_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RST;
      timer_q   <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      resetb_q  <= 1'b0;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      resetb_q  <= resetb_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    loss_d     = loss_q;
    retry_path = 1'b0;

    if (bus.restart) begin
      state_d = PLL_RST;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (timer_q == TW'(RESET_CYCLES - 1)) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            timer_d = '0;
          end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
            retry_path = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        // A drop on the final stable cycle must still count as a failed attempt.
        STABLE: begin
          if (!lock_s) begin
            retry_path = 1'b1;
          end else if (timer_q == TW'(STABLE_CYCLES - 1)) begin
            state_d = RUN;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        RUN: begin
          retry_d = '0;
          if (!lock_s) begin
            if (loss_q != {CNT_W{1'b1}}) loss_d = loss_q + 1'b1;
            state_d = PLL_RST;
            timer_d = '0;
          end
        end
        default: ;
      endcase

      if (retry_path) begin
        timer_d = '0;
        if (retry_q == RC_W'(MAX_RETRIES - 1)) begin
          state_d = EXHAUSTED;
        end else begin
          retry_d = retry_q + 1'b1;
          state_d = PLL_RST;
        end
      end
    end

    // Outputs are decoded from the next state so they register on the same edge.
    resetb_d  = 1'b1;
    sys_rst_d = 1'b1;
    ready_d   = 1'b0;
    fault_d   = 1'b0;
    bypass_d  = 1'b0;
    case (state_d)
      PLL_RST: resetb_d = 1'b0;
      RUN: begin
        sys_rst_d = 1'b0;
        ready_d   = 1'b1;
      end
      FAULT: begin
        resetb_d = 1'b0;
        fault_d  = 1'b1;
      end
`ifdef PLL_BYPASS_FALLBACK_EN
      BYPASS: begin
        resetb_d  = 1'b0;
        sys_rst_d = 1'b0;
        ready_d   = 1'b1;
        fault_d   = 1'b1;
        bypass_d  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifdef PLL_BYPASS_FALLBACK_EN
  logic bypass_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bypass_q <= 1'b0;
    else     bypass_q <= bypass_d;
  end

  assign bus.pll_bypass = bypass_q;
`else
  logic unused_bypass;
  assign unused_bypass  = bypass_d;
  assign bus.pll_bypass = 1'b0;
`endif

  assign bus.pll_resetb      = resetb_q;
  assign bus.sys_rst         = sys_rst_q;
  assign bus.ready           = ready_q;
  assign bus.fault           = fault_q;
  assign bus.retry_count     = retry_q;
  assign bus.lock_loss_count = loss_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed and randomized checks of pll_reset_sequencer against a reference model
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  localparam int RESET_CYCLES  = 16;
  localparam int LOCK_TIMEOUT  = 4096;
  localparam int STABLE_CYCLES = 256;
  localparam int MAX_RETRIES   = 3;
  localparam int CNT_W         = 8;
  localparam int RC_W          = retry_width(MAX_RETRIES);

  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAULT = 4, P_BYP = 5;
`ifdef PLL_BYPASS_FALLBACK_EN
  localparam int P_EXH = P_BYP;
`else
  localparam int P_EXH = P_FAULT;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_reset_sequencer_if #(.RC_W(RC_W), .CNT_W(CNT_W)) bus ();

  pll_reset_sequencer #(
    .RESET_CYCLES  (RESET_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: phase plus elapsed cycles, lock seen through a two-sample history.
  int m_ph, m_t, m_retry, m_loss;
  bit m_l1, m_l2;

  task automatic model_reset();
    m_ph = P_RST; m_t = 0; m_retry = 0; m_loss = 0; m_l1 = 0; m_l2 = 0;
  endtask

  task automatic model_edge();
    bit seen, failed;
    seen   = m_l2;
    m_l2   = m_l1;
    m_l1   = bus.pll_lock;
    failed = 0;
    if (bus.restart) begin
      m_ph = P_RST; m_t = 0; m_retry = 0;
      return;
    end
    case (m_ph)
      P_RST: begin
        m_t++;
        if (m_t == RESET_CYCLES) begin m_ph = P_WAIT; m_t = 0; end
      end
      P_WAIT: begin
        if (seen) begin m_ph = P_STAB; m_t = 0; end
        else begin m_t++; if (m_t == LOCK_TIMEOUT) failed = 1; end
      end
      P_STAB: begin
        if (!seen) failed = 1;
        else begin
          m_t++;
          if (m_t == STABLE_CYCLES) begin m_ph = P_RUN; m_t = 0; m_retry = 0; end
        end
      end
      P_RUN: begin
        m_retry = 0;
        if (!seen) begin
          if (m_loss < (1 << CNT_W) - 1) m_loss++;
          m_ph = P_RST; m_t = 0;
        end
      end
      default: ;
    endcase
    if (failed) begin
      m_t = 0;
      if (m_retry + 1 >= MAX_RETRIES) m_ph = P_EXH;
      else begin m_retry++; m_ph = P_RST; end
    end
  endtask

  task automatic compare_all();
    bit parked, running;
    parked  = (m_ph == P_RST) || (m_ph == P_FAULT) || (m_ph == P_BYP);
    running = (m_ph == P_RUN) || (m_ph == P_BYP);
    check_eq("pll_resetb", bus.pll_resetb, !parked);
    check_eq("pll_bypass", bus.pll_bypass, m_ph == P_BYP);
    check_eq("sys_rst", bus.sys_rst, !running);
    check_eq("ready", bus.ready, running);
    check_eq("fault", bus.fault, (m_ph == P_FAULT) || (m_ph == P_BYP));
    check_eq("retry_count", bus.retry_count, m_retry);
    check_eq("lock_loss_count", bus.lock_loss_count, m_loss);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_restart();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
  endtask

  initial begin
    int t_ref, lows, budget;
    bit prev_resetb, saw_ready;
    int rises[$];

    bus.restart  = 1'b0;
    bus.pll_lock = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    check_eq("reset_sys_rst", bus.sys_rst, 1);
    rst = 1'b0;
    cyc = 0;

    // Normal bring-up
    for (int i = 0; i < 40 && !bus.pll_resetb; i++) tick();
    check_eq("resetb_rise_cycle", cyc, RESET_CYCLES);
    repeat (99) tick();
    bus.pll_lock = 1'b1;
    t_ref = cyc + 1;
    for (int i = 0; i < 400 && !bus.ready; i++) tick();
    check_eq("ready_latency", cyc - t_ref, 2 + STABLE_CYCLES);
    check_eq("sys_rst_with_ready", bus.sys_rst, 0);
    repeat (10) tick();

    // Lock loss in RUN
    bus.pll_lock = 1'b0;
    t_ref = cyc;
    for (int i = 0; i < 6 && !bus.sys_rst; i++) tick();
    check_eq("loss_latency", cyc - t_ref, 3);
    check_eq("loss_ready", bus.ready, 0);
    check_eq("loss_count", bus.lock_loss_count, 1);
    check_eq("loss_retry", bus.retry_count, 0);
    repeat (20) tick();
    bus.pll_lock = 1'b1;
    for (int i = 0; i < 400 && !bus.ready; i++) tick();
    check_eq("resequence_ready", bus.ready, 1);

    // Lock glitch at stable timer 100
    pulse_restart();
    for (int i = 0; i < 400 && !(m_ph == P_STAB && m_t == 100); i++) tick();
    check_eq("glitch_reached_stable", m_ph == P_STAB && m_t == 100, 1);
    saw_ready = 0;
    bus.pll_lock = 1'b0;
    repeat (3) begin tick(); saw_ready |= bus.ready; end
    bus.pll_lock = 1'b1;
    for (int i = 0; i < 10 && bus.pll_resetb; i++) begin tick(); saw_ready |= bus.ready; end
    check_eq("glitch_resetb", bus.pll_resetb, 0);
    check_eq("glitch_retry", bus.retry_count, 1);
    check_eq("glitch_no_ready", saw_ready, 0);

    // Lock never asserts
    bus.pll_lock = 1'b0;
    repeat (5) tick();
    pulse_restart();
    lows = (!bus.pll_resetb && !bus.fault) ? 1 : 0;
    prev_resetb = bus.pll_resetb;
    budget = MAX_RETRIES * (RESET_CYCLES + LOCK_TIMEOUT) + 50;
    for (int i = 0; i < budget && !bus.fault; i++) begin
      tick();
      if (!bus.pll_resetb && !bus.fault) lows++;
      if (bus.pll_resetb && !prev_resetb) rises.push_back(int'(bus.retry_count));
      prev_resetb = bus.pll_resetb;
    end
    check_eq("nolock_fault", bus.fault, 1);
    check_eq("nolock_resetb", bus.pll_resetb, 0);
    check_eq("nolock_low_cycles", lows, MAX_RETRIES * RESET_CYCLES);
    check_eq("nolock_pulses", rises.size(), MAX_RETRIES);
    foreach (rises[k]) check_eq($sformatf("nolock_retry_%0d", k), rises[k], k);
`ifdef PLL_BYPASS_FALLBACK_EN
    check_eq("nolock_bypass", bus.pll_bypass, 1);
    check_eq("nolock_ready", bus.ready, 1);
`else
    check_eq("nolock_bypass", bus.pll_bypass, 0);
    check_eq("nolock_ready", bus.ready, 0);
`endif
    repeat (20) tick();

    // restart from FAULT
    pulse_restart();
    check_eq("restart_fault", bus.fault, 0);
    check_eq("restart_retry", bus.retry_count, 0);
    check_eq("restart_loss", bus.lock_loss_count, 1);
    bus.pll_lock = 1'b1;
    for (int i = 0; i < 400 && !bus.ready; i++) tick();
    check_eq("restart_ready", bus.ready, 1);
    repeat (5) tick();

    // Async rst in RUN
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_sys_rst", bus.sys_rst, 1);
    check_eq("arst_resetb", bus.pll_resetb, 0);
    check_eq("arst_ready", bus.ready, 0);
    check_eq("arst_retry", bus.retry_count, 0);
    check_eq("arst_loss", bus.lock_loss_count, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    // Randomized lock behaviour with occasional restarts
    for (int seg = 0; seg < 40; seg++) begin
      int len;
      if ($urandom_range(0, 15) == 0 || m_ph == P_FAULT || m_ph == P_BYP) pulse_restart();
      bus.pll_lock = ~bus.pll_lock;
      len = bus.pll_lock ? $urandom_range(1, 700) : $urandom_range(1, 60);
      repeat (len) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
